calc_sequencer: RTL
===================

# calc_sequencer

Multi-cycle operation sequencer for the calculator datapath. Accepts one opcode per handshake and steps the shared adder/subtractor and an iterative shift-add multiplier through it. Holds the previous-result register used by the ToPrev opcodes and returns one result per accepted operation. Sits between the operand/opcode source and the result/memory writeback.

## Interface
- WIDTH, 8: operand, result and previous-result width in bits (≥4)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- op_valid  in  1  opcode/operands present
- op_ready  out  1  high only in IDLE and not in reset; transfer on op_valid & op_ready
- funct  in  3  opcode, sampled on transfer
- a  in  WIDTH  operand A, sampled on transfer
- b  in  WIDTH  operand B, sampled on transfer
- clear_prev  in  1  zero the previous-result register
- result  out  WIDTH  last completed result, held until next completion
- res_valid  out  1  one-cycle completion pulse
- ovf  out  1  overflow of last completion, valid with res_valid and held
- err  out  1  last completion was illegal opcode or divide-by-zero, held
- busy  out  1  state ≠ IDLE

## Operation
- Opcodes (unsigned, mod 2^WIDTH):
  - 000 ADD: a+b
  - 001 SUB: a−b
  - 010 MULT: a*b
  - 100 ADDToPrev: prev+a
  - 101 SUBToPrev: prev−a
  - 110 MULTWithPrev: prev*a
  - 111 DIV, 011 DIVByPrev: see Configuration
- Operands are latched on transfer. Later a/b/funct changes and clear_prev do not affect an operation in flight.
- FSM states: IDLE, ADDSUB, MUL, DIV, DONE.
  - IDLE→ADDSUB for 000/001/100/101
  - IDLE→MUL for 010/110
  - IDLE→DIV for 111/011 (macro on only)
  - IDLE→DONE with err for illegal opcodes
  - ADDSUB→DONE after 1 cycle
  - MUL/DIV→DONE when the iteration counter reaches WIDTH−1
  - DONE→IDLE unconditionally
- ADDSUB: result = sum or difference. ovf = carry-out for add, borrow for subtract.
- MUL: shift-add over a 2·WIDTH product, one multiplier bit per cycle, LSB first. result = low WIDTH bits. ovf = (high half ≠ 0).
- Completion, legal and err=0: result, ovf and prev update, err=0.
- Completion with err=1: result and prev unchanged, ovf=0.
- clear_prev: prev←0 at that edge. If it coincides with a completion writing prev, the completion wins.
- A ToPrev opcode accepted on the same edge as clear_prev uses the old prev value.

## Timing
- Reset values: state IDLE, result=0, prev=0, res_valid=0, ovf=0, err=0, busy=0, op_ready=0 during reset and 1 the first cycle after.
- Latency counts cycles from the transfer edge to the res_valid cycle:
  - ADD/SUB family: 2
  - MUL family: WIDTH+1
  - DIV family: WIDTH+1
  - illegal opcode: 1
- res_valid lasts exactly 1 cycle (DONE). op_ready returns the cycle after DONE, so the minimum ADD-to-ADD issue interval is 3 cycles.
- No back-pressure on results. The consumer must capture result in the res_valid cycle or any cycle before the next completion.
- Reset asserted mid-operation abandons it: no res_valid pulse, and result/prev return to 0.

## Configuration
- CALC_DIV_EN defined: 111 = a/b and 011 = prev/a, restoring division, one quotient bit per cycle, MSB first.
  - result = quotient, ovf = 0.
  - Divisor 0: result unchanged, err=1, latency still WIDTH+1.
- CALC_DIV_EN undefined: 111 and 011 are illegal opcodes (err=1, latency 1). No DIV state or divider logic is built.

## Test plan
- WIDTH=8, reset, then ADD a=100 b=27 → res_valid 2 cycles later, result=127, ovf=0, prev=127.
- After that, SUBToPrev a=200 → result=183 (127−200 mod 256), ovf=1.
- MULT a=16 b=20 → res_valid 9 cycles after transfer, result=64, ovf=1. Then MULTWithPrev a=3 → result=192, ovf=0.
- Hold op_valid high with ADD/ADD back-to-back → transfers exactly 3 cycles apart, and op_ready=0 while busy.
- With CALC_DIV_EN: DIV a=200 b=7 → result=28, latency 9. DIV b=0 → err=1, result stays 28.
  - Without CALC_DIV_EN: funct=111 → err=1, latency 1, result unchanged.
- Assert reset 4 cycles into a MULT → no res_valid, result=0, op_ready=1 the cycle after reset drops. A clear_prev coincident with ADDToPrev acceptance → the op uses the old prev.

Source files
------------

// File: rtl/calc_sequencer.sv
// Multi-cycle calculator sequencer: add/sub, shift-add multiply and an optional restoring divider.
// Optional divider is built only when CALC_DIV_EN is defined.
module calc_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clear_prev,
    output logic [WIDTH-1:0] result,
    output logic             res_valid,
    output logic             ovf,
    output logic             err,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] F_ADD  = 3'b000;
    localparam logic [2:0] F_SUB  = 3'b001;
    localparam logic [2:0] F_MUL  = 3'b010;
    localparam logic [2:0] F_DIVP = 3'b011;
    localparam logic [2:0] F_ADDP = 3'b100;
    localparam logic [2:0] F_SUBP = 3'b101;
    localparam logic [2:0] F_MULP = 3'b110;
`ifdef CALC_DIV_EN
    localparam logic [2:0] F_DIV  = 3'b111;
`endif

`ifdef CALC_DIV_EN
    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DONE} state_t;
`endif

    state_t                 state_reg;
    logic [WIDTH-1:0]       x_reg;
    logic [WIDTH-1:0]       y_reg;
    logic                   sub_reg;
    logic [CW-1:0]          cnt_reg;
    logic [2*WIDTH-1:0]     prod_reg;
    logic [2*WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]       result_reg;
    logic [WIDTH-1:0]       prev_reg;
    logic                   ovf_reg;
    logic                   err_reg;
    logic                   res_valid_reg;

    // ToPrev opcodes take prev as the first operand and a as the second.
    logic                   uses_prev;
    logic [WIDTH-1:0]       opx;
    logic [WIDTH-1:0]       opy;

    always_comb begin
        uses_prev = (funct == F_ADDP) || (funct == F_SUBP) ||
                    (funct == F_MULP) || (funct == F_DIVP);
        opx       = uses_prev ? prev_reg : a;
        opy       = uses_prev ? a : b;
    end

    logic [WIDTH:0]         sum_ext;
    logic [WIDTH:0]         diff_ext;
    logic [WIDTH:0]         as_ext;
    logic [2*WIDTH-1:0]     prod_next;

    assign sum_ext   = {1'b0, x_reg} + {1'b0, y_reg};
    assign diff_ext  = {1'b0, x_reg} - {1'b0, y_reg};
    assign as_ext    = sub_reg ? diff_ext : sum_ext;
    assign prod_next = prod_reg + (y_reg[0] ? mcand_reg : {(2*WIDTH){1'b0}});

`ifdef CALC_DIV_EN
    // Restoring step: dividend shifts out of x_reg MSB first while quotient bits shift in.
    logic [WIDTH-1:0]       rem_reg;
    logic [WIDTH:0]         rem_shift;
    logic [WIDTH:0]         div_diff;
    logic                   q_bit;
    logic [WIDTH-1:0]       rem_next;
    logic [WIDTH-1:0]       quo_next;

    assign rem_shift = {rem_reg, x_reg[WIDTH-1]};
    assign div_diff  = rem_shift - {1'b0, y_reg};
    assign q_bit     = ~div_diff[WIDTH];
    assign rem_next  = q_bit ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_next  = {x_reg[WIDTH-2:0], q_bit};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            sub_reg       <= 1'b0;
            cnt_reg       <= '0;
            prod_reg      <= '0;
            mcand_reg     <= '0;
            result_reg    <= '0;
            prev_reg      <= '0;
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
            res_valid_reg <= 1'b0;
`ifdef CALC_DIV_EN
            rem_reg       <= '0;
`endif
        end else begin
            res_valid_reg <= 1'b0;
            // A completion later in this block overrides the clear.
            if (clear_prev) begin
                prev_reg <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (op_valid) begin
                        x_reg     <= opx;
                        y_reg     <= opy;
                        sub_reg   <= funct[0];
                        cnt_reg   <= '0;
                        prod_reg  <= '0;
                        mcand_reg <= {{WIDTH{1'b0}}, opx};
`ifdef CALC_DIV_EN
                        rem_reg   <= '0;
`endif
                        case (funct)
                            F_ADD, F_SUB, F_ADDP, F_SUBP: state_reg <= ADDSUB;
                            F_MUL, F_MULP:                state_reg <= MUL;
`ifdef CALC_DIV_EN
                            F_DIV, F_DIVP:                state_reg <= DIV;
`endif
                            default: begin
                                state_reg     <= DONE;
                                res_valid_reg <= 1'b1;
                                ovf_reg       <= 1'b0;
                                err_reg       <= 1'b1;
                            end
                        endcase
                    end
                end

                ADDSUB: begin
                    state_reg     <= DONE;
                    res_valid_reg <= 1'b1;
                    result_reg    <= as_ext[WIDTH-1:0];
                    prev_reg      <= as_ext[WIDTH-1:0];
                    ovf_reg       <= as_ext[WIDTH];
                    err_reg       <= 1'b0;
                end

                MUL: begin
                    prod_reg  <= prod_next;
                    mcand_reg <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                    y_reg     <= {1'b0, y_reg[WIDTH-1:1]};
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        state_reg     <= DONE;
                        res_valid_reg <= 1'b1;
                        result_reg    <= prod_next[WIDTH-1:0];
                        prev_reg      <= prod_next[WIDTH-1:0];
                        ovf_reg       <= |prod_next[2*WIDTH-1:WIDTH];
                        err_reg       <= 1'b0;
                    end
                end

`ifdef CALC_DIV_EN
                DIV: begin
                    x_reg   <= quo_next;
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        state_reg     <= DONE;
                        res_valid_reg <= 1'b1;
                        ovf_reg       <= 1'b0;
                        // Zero divisor still runs the full iteration so latency is fixed.
                        if (y_reg == '0) begin
                            err_reg <= 1'b1;
                        end else begin
                            err_reg    <= 1'b0;
                            result_reg <= quo_next;
                            prev_reg   <= quo_next;
                        end
                    end
                end
`endif

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign op_ready  = (state_reg == IDLE) && !reset;
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;
    assign res_valid = res_valid_reg;
    assign ovf       = ovf_reg;
    assign err       = err_reg;

endmodule
